// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers: bit-serial shift-add
// multiply and restoring divide. Define MDU_MACC_EN to enable madd/maddu/msub/msubu.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             cancel,
  input  logic             r_sel,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi, lo, a_q, divr;
  logic [PW-1:0] prod;
  logic          is_div, neg_p, neg_r, div0;
`ifdef MDU_MACC_EN
  logic          is_macc, is_sub;
  logic [PW-1:0] acc;
`endif

  logic          op_ok, accept, sa, sb;
  logic [W-1:0]  a_mag, b_mag, q_s, r_s;
  logic [W:0]    mul_sum, rem_sh, diff;
  logic [PW-1:0] prod_s;

`ifdef MDU_MACC_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[2];
`endif

  assign accept = start && op_ok && !hi_we && !lo_we && !cancel;
  assign busy   = (state != IDLE) || accept;
  assign r      = r_sel ? hi : lo;

  // Magnitudes: operands are sign-treated only for the signed (even) ops
  assign sa    = ~op[0] & a[W-1];
  assign sb    = ~op[0] & b[W-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;

  // One iteration step; multiply and divide share the product register
  assign mul_sum = {1'b0, prod[PW-1:W]} + {1'b0, {W{prod[0]}} & divr};
  assign rem_sh  = {prod[PW-1:W], prod[W-1]};
  assign diff    = rem_sh - {1'b0, divr};

  assign prod_s = neg_p ? -prod : prod;
  assign q_s    = neg_p ? -prod[W-1:0] : prod[W-1:0];
  assign r_s    = neg_r ? -prod[PW-1:W] : prod[PW-1:W];
`ifdef MDU_MACC_EN
  assign acc    = is_sub ? ({hi, lo} - prod_s) : ({hi, lo} + prod_s);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      a_q    <= '0;
      divr   <= '0;
      prod   <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done   <= 1'b0;
`ifdef MDU_MACC_EN
      is_macc <= 1'b0;
      is_sub  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (hi_we || lo_we) begin
              if (hi_we) hi <= a;
              if (lo_we) lo <= a;
            end else if (accept) begin
              a_q    <= a;
              divr   <= b_mag;
              prod   <= {W'(0), a_mag};
              is_div <= op[1] & ~op[2];
              neg_p  <= sa ^ sb;
              neg_r  <= sa;
              div0   <= (b == '0);
              cnt    <= CW'(W);
              state  <= RUN;
`ifdef MDU_MACC_EN
              is_macc <= op[2];
              is_sub  <= op[1];
`endif
            end
          end
          RUN: begin
            if (is_div)
              prod <= {diff[W] ? rem_sh[W-1:0] : diff[W-1:0], prod[W-2:0], ~diff[W]};
            else
              prod <= {mul_sum, prod[W-1:1]};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              lo <= div0 ? '1 : q_s;
              hi <= div0 ? a_q : r_s;
`ifdef MDU_MACC_EN
            end else if (is_macc) begin
              {hi, lo} <= acc;
`endif
            end else begin
              {hi, lo} <= prod_s;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter at WIDTH=32.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we, cancel, r_sel;
  logic [31:0] a, b, r;
  logic [2:0]  op;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .cancel(cancel), .r_sel(r_sel),
    .r(r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    r_sel = 1'b1; #1 h = r;
    r_sel = 1'b0; #1 l = r;
  endtask

  task automatic wr(input logic hw, input logic lw, input logic [31:0] v);
    @(negedge clk); hi_we = hw; lo_we = lw; a = v;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Launch one op and watch busy/done over a bounded window
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nbusy, output int ndone);
    nbusy = 0; ndone = 0;
    @(negedge clk); op = o; a = x; b = y; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy) nbusy++;
      if (done) ndone++;
      @(negedge clk); start = 1'b0;
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int nb, nd;
    logic [31:0] h, l;
    run_op(o, x, y, nb, nd);
    read_hl(h, l);
    check({tag, " hi"}, 64'(h), 64'(eh));
    check({tag, " lo"}, 64'(l), 64'(el));
    check({tag, " done"}, 64'(nd), 64'd1);
  endtask

  initial begin
    int nb, nd;
    logic [31:0] h, l;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; cancel = 1'b0;
    r_sel = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    read_hl(h, l);
    check("rst hi", 64'(h), 64'd0);
    check("rst lo", 64'(l), 64'd0);

    run_op(3'b000, 32'hFFFF_FFFF, 32'h2, nb, nd);
    read_hl(h, l);
    check("mult busy", 64'(nb), 64'd34);
    check("mult done", 64'(nd), 64'd1);
    check("mult hi", 64'(h), 64'hFFFF_FFFF);
    check("mult lo", 64'(l), 64'hFFFF_FFFE);

    op_check("multu", 3'b001, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);
    op_check("mult nn", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
    op_check("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_check("divu 7/2", 3'b011, 32'h7, 32'h2, 32'h1, 32'h3);
    op_check("div 5/0", 3'b010, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF);
    op_check("div -5/0", 3'b010, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    op_check("div ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op(3'b011, 32'h0, 32'h0, nb, nd);
    check("divu0 busy", 64'(nb), 64'd34);

    // Cancel mid-divide
    wr(1'b1, 1'b0, 32'h11);
    wr(1'b0, 1'b1, 32'h22);
    @(negedge clk); op = 3'b010; a = 32'd100; b = 32'd7; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = 1'b0;
    end
    cancel = 1'b1; #1;
    check("cancel busy pre", 64'(busy), 64'd1);
    @(negedge clk); cancel = 1'b0; #1;
    check("cancel busy post", 64'(busy), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) nd++;
    end
    check("cancel done", 64'(nd), 64'd0);
    read_hl(h, l);
    check("cancel hi", 64'(h), 64'h11);
    check("cancel lo", 64'(l), 64'h22);

    // start / writes while busy are ignored
    @(negedge clk); op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    op = 3'b000; a = 32'd5; b = 32'd5; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
    @(negedge clk); start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) nd++;
    end
    check("busyign done", 64'(nd), 64'd1);
    read_hl(h, l);
    check("busyign hi", 64'(h), 64'd2);
    check("busyign lo", 64'(l), 64'd14);

    // hi_we with start in IDLE writes HI and launches nothing
    @(negedge clk); op = 3'b000; a = 32'h33; b = 32'd5; start = 1'b1; hi_we = 1'b1; #1;
    check("wr+start busy", 64'(busy), 64'd0);
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    check("wr+start nbusy", 64'(nb), 64'd0);
    check("wr+start done", 64'(nd), 64'd0);
    read_hl(h, l);
    check("wr+start hi", 64'(h), 64'h33);
    check("wr+start lo", 64'(l), 64'd14);

    // Reset mid-op aborts with no done
    @(negedge clk); op = 3'b001; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    check("rstmid busy", 64'(busy), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) nd++;
    end
    check("rstmid done", 64'(nd), 64'd0);
    read_hl(h, l);
    check("rstmid hilo", {h, l}, 64'd0);

`ifdef MDU_MACC_EN
    wr(1'b1, 1'b0, 32'h0);
    wr(1'b0, 1'b1, 32'h5);
    op_check("madd", 3'b100, 32'd3, 32'd4, 32'h0, 32'h11);
    op_check("msubu", 3'b111, 32'd1, 32'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    wr(1'b1, 1'b1, 32'hAB);
    @(negedge clk); op = 3'b100; a = 32'd3; b = 32'd4; start = 1'b1; #1;
    check("op100 busy", 64'(busy), 64'd0);
    @(negedge clk); start = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    check("op100 nbusy", 64'(nb), 64'd0);
    check("op100 done", 64'(nd), 64'd0);
    read_hl(h, l);
    check("op100 hilo", {h, l}, {32'hAB, 32'hAB});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
